tag_fifo: RTL

Free-tag pool for register renaming in the out-of-order core. It holds every unused 6-bit rename tag in a circular FIFO. On an allocation request it hands the head tag to dispatch, which writes it into the register status table as {valid, tag}. Tags come back on the CDB broadcast and are re-enqueued. The block sits directly upstream of the register status table write port 0 and shares the CDB tag bus with it.

---
 rtl/tag_fifo.sv | 56 +++++
 1 files changed

// File: rtl/tag_fifo.sv
// tag_fifo: free rename-tag pool, a circular FIFO preloaded with every tag.
// Allocation is first-word fall-through; CDB-returned tags are re-enqueued.
module tag_fifo #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_valid,
    output logic [TAG_W:0]   rst_wdata,
    output logic             rst_wen,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic [TAG_W:0]   free_count,
    output logic             overflow,
    output logic             underflow
);
    localparam int DEPTH = 1 << TAG_W;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [TAG_W:0]   rd_ptr;
    logic [TAG_W:0]   wr_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;

    assign empty = rd_ptr == wr_ptr;
    assign full  = (rd_ptr[TAG_W-1:0] == wr_ptr[TAG_W-1:0]) && (rd_ptr[TAG_W] != wr_ptr[TAG_W]);
    assign pop   = alloc_req & ~empty;
    // A pop frees the slot this edge, so a push at full is still accepted alongside it.
    assign push  = cdb_valid & (~full | pop);

    assign alloc_tag   = mem[rd_ptr[TAG_W-1:0]];
    assign alloc_valid = ~empty;
    assign rst_wen     = pop;
    assign rst_wdata   = {1'b1, alloc_tag};
    assign free_count  = wr_ptr - rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(i);
            rd_ptr    <= '0;
            wr_ptr    <= {1'b1, {TAG_W{1'b0}}};
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) mem[wr_ptr[TAG_W-1:0]] <= cdb_tag;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            overflow  <= overflow | (cdb_valid & ~push);
            underflow <= underflow | (alloc_req & empty);
        end
    end
endmodule
